lif_synapse_driver: RTL

//  Upstream stage of the LIF neuron. Converts presynaptic spike events into the 8-bit
//  'current' bus that drives the neuron's current input.

---
 rtl/lif_synapse_driver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lif_synapse_driver.sv
// Synaptic current driver for a LIF neuron: serially sums spiked weights, leaks, saturates to 8 bits.
// Spike accept to current update is N_IN+1 edges; spike_ready_o is low from accept until back in IDLE.
module lif_synapse_driver #(
  parameter int         N_IN        = 4,
  parameter int         AW          = 2,
  parameter int         DECAY_SHIFT = 2,
  parameter logic [7:0] W_RESET     = 8'd0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_IN-1:0] spike_in_i,
  input  logic            spike_valid_i,
  output logic            spike_ready_o,
  input  logic            decay_tick_i,
  input  logic            w_we_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [7:0]      w_data_i,
  output logic [7:0]      current_o,
  output logic            current_valid_o,
  output logic            sat_flag_o
);

  localparam int ACW = 8 + AW + 1;
  localparam int SW  = 8 + AW + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, UPD, UPD_D} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [ACW-1:0]    acc_q, acc_d;
  logic [N_IN-1:0]   spikes_q, spikes_d;
  logic [7:0]        current_q, current_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;
  logic [7:0]        w_q [N_IN];

  logic [7:0]        leak;
  logic [ACW-1:0]    addend;
  logic [SW-1:0]     sum;

  // A shift of zero means no leak rather than a full drain.
  assign leak   = (DECAY_SHIFT == 0) ? 8'd0 : (current_q >> DECAY_SHIFT);
  assign addend = spikes_q[idx_q] ? {{(ACW-8){1'b0}}, w_q[idx_q]} : '0;
  assign sum    = {{(SW-8){1'b0}}, current_q} - {{(SW-8){1'b0}}, leak} + {1'b0, acc_q};

  assign spike_ready_o   = (state_q == IDLE) && !reset_i;
  assign current_o       = current_q;
  assign current_valid_o = valid_q;
  assign sat_flag_o      = sat_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    current_d = current_q;
    valid_d   = 1'b0;
    sat_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick coinciding with an accept is absorbed: the spike update already leaks.
        if (spike_valid_i) begin
          state_d  = ACCUM;
          idx_d    = '0;
          acc_d    = '0;
          spikes_d = spike_in_i;
        end else if (decay_tick_i) begin
          state_d = UPD_D;
        end
      end
      ACCUM: begin
        acc_d = acc_q + addend;
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(N_IN - 1)) begin
          state_d = UPD;
        end
      end
      UPD: begin
        current_d = (sum > SW'(255)) ? 8'hFF : sum[7:0];
        valid_d   = 1'b1;
        sat_d     = (sum > SW'(255));
        state_d   = IDLE;
      end
      UPD_D: begin
        current_d = current_q - leak;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      spikes_q  <= '0;
      current_q <= 8'd0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      current_q <= current_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
    end
  end

  // Writes land on the edge, so an ACCUM read of the same index sees the old weight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= W_RESET;
      end
    end else if (w_we_i && (32'(w_addr_i) < 32'(N_IN))) begin
      w_q[w_addr_i] <= w_data_i;
    end
  end

endmodule
